// File: rtl/ccip_avmm_pkg.sv
// Shared CCI-P / Avalon-MM bridge types and helpers.
// Used by the host read and write bridges.
package ccip_avmm_pkg;

    localparam int CCIP_AVMM_REQUESTOR_WR_ADDR_WIDTH = 48;
    localparam int CCIP_AVMM_REQUESTOR_DATA_WIDTH    = 512;
    localparam int CCIP_AVMM_REQUESTOR_BURST_WIDTH   = 3;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eVC_VA  = 2'd0,
        eVC_VL0 = 2'd1,
        eVC_VH0 = 2'd2,
        eVC_VH1 = 2'd3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'd0,
        eCL_LEN_2 = 2'd1,
        eCL_LEN_4 = 2'd3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        logic         sop;
        logic         rsvd0;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd2;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    // A burst must be split into single lines when it is not a
    // naturally aligned 1/2/4-line packet.
    function automatic logic ccip_avmm_burst_chop(
        input logic [1:0] addr,
        input logic [2:0] burstcount
    );
        return (burstcount == 3'd3) ||
               ((burstcount == 3'd2) && addr[0]) ||
               ((burstcount == 3'd4) && (addr != 2'b00));
    endfunction

    function automatic t_ccip_clLen ccip_avmm_cl_len(
        input logic [2:0] burstcount
    );
        case (burstcount)
            3'd2:    return eCL_LEN_2;
            3'd4:    return eCL_LEN_4;
            default: return eCL_LEN_1;
        endcase
    endfunction

endpackage

// File: rtl/avmm_ccip_wr_len_fifo.sv
// Burst-length FIFO for the host write bridge.
// Show-ahead: the head entry is visible on pop_data while not empty.
module avmm_ccip_wr_len_fifo #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [2:0] push_data,
    input  logic       pop,
    output logic [2:0] pop_data,
    output logic       full,
    output logic       empty
);

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage write; no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; push and pop may coincide even when full.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avmm_ccip_host_wr.sv
// Avalon-MM write slave to CCI-P c1 write-request bridge.
// One Avalon write response per burst, counted from c1 responses.
module avmm_ccip_host_wr
    import ccip_avmm_pkg::*;
#(
    parameter int RSP_FIFO_DEPTH = 64,
    parameter int RSP_FIFO_AW    = $clog2(RSP_FIFO_DEPTH)
) (
    input  logic                                         clk,
    input  logic                                         reset,
    output logic                                         avmm_waitrequest,
    input  logic [CCIP_AVMM_REQUESTOR_WR_ADDR_WIDTH-1:0] avmm_address,
    input  logic                                         avmm_write,
    input  logic [CCIP_AVMM_REQUESTOR_DATA_WIDTH-1:0]    avmm_writedata,
    input  logic [CCIP_AVMM_REQUESTOR_BURST_WIDTH-1:0]   avmm_burstcount,
    output logic                                         avmm_writeresponsevalid,
    input  logic                                         c1TxAlmFull,
    input  t_if_ccip_c1_Rx                               c1rx,
    output t_if_ccip_c1_Tx                               c1tx
);

    logic         avcmd_ready;
    logic [2:0]   beat_cnt;
    logic         first_beat;
    logic         beat_acc;

    t_ccip_clAddr a_q;
    logic [2:0]   l_q;
    logic         chop_q;
    logic [1:0]   idx_q;

    t_ccip_clAddr cur_a;
    logic [2:0]   cur_l;
    logic         cur_chop;
    logic [1:0]   cur_idx;

    logic         hdr_sop;
    t_ccip_clLen  hdr_len;
    t_ccip_clAddr hdr_addr;
    t_ccip_mdata  mdata_q;

    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    logic [2:0]   fifo_head;

    logic         rsp_wr;
    logic [8:0]   rsp_lines;
    logic [8:0]   pop_lines;
    logic [8:0]   done_lines;

    logic         unused_bits;

    assign first_beat = (beat_cnt == 3'd0);
    assign avmm_waitrequest = ~avcmd_ready | (first_beat & fifo_full);
    assign beat_acc   = avmm_write & ~avmm_waitrequest;

    // Almost-full is registered; its slack covers the extra cycle.
    always_ff @(posedge clk) begin
        if (reset) avcmd_ready <= 1'b0;
        else       avcmd_ready <= ~c1TxAlmFull;
    end

    // Select the burst parameters for the beat being accepted now.
    always_comb begin
        cur_a    = a_q;
        cur_l    = l_q;
        cur_chop = chop_q;
        cur_idx  = idx_q;
        if (first_beat) begin
            cur_a    = avmm_address[47:6];
            cur_l    = avmm_burstcount;
            cur_chop = ccip_avmm_burst_chop(avmm_address[7:6], avmm_burstcount);
            cur_idx  = 2'd0;
        end
    end

    // Build the c1 header fields for the current beat.
    always_comb begin
        hdr_sop  = 1'b1;
        hdr_len  = eCL_LEN_1;
        hdr_addr = cur_a + 42'(cur_idx);
        if (!cur_chop) begin
            hdr_sop  = (cur_idx == 2'd0);
            hdr_len  = ccip_avmm_cl_len(cur_l);
            hdr_addr = {cur_a[41:2], cur_a[1:0] | cur_idx};
        end
    end

    // Burst tracking: capture on first beat, count down later beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= 3'd0;
            a_q      <= '0;
            l_q      <= 3'd0;
            chop_q   <= 1'b0;
            idx_q    <= 2'd0;
        end else if (beat_acc) begin
            if (first_beat) begin
                beat_cnt <= avmm_burstcount - 3'd1;
                a_q      <= cur_a;
                l_q      <= cur_l;
                chop_q   <= cur_chop;
                idx_q    <= 2'd1;
            end else begin
                beat_cnt <= beat_cnt - 3'd1;
                idx_q    <= idx_q + 2'd1;
            end
        end
    end

    // Registered c1 request, one per accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            c1tx    <= '0;
            mdata_q <= '0;
        end else begin
            c1tx.valid <= beat_acc;
            if (beat_acc) begin
                c1tx.hdr.vc_sel   <= eVC_VH0;
                c1tx.hdr.rsvd1    <= '0;
                c1tx.hdr.sop      <= hdr_sop;
                c1tx.hdr.rsvd0    <= 1'b0;
                c1tx.hdr.cl_len   <= hdr_len;
                c1tx.hdr.req_type <= eREQ_WRLINE_I;
                c1tx.hdr.rsvd2    <= '0;
                c1tx.hdr.address  <= hdr_addr;
                c1tx.hdr.mdata    <= mdata_q;
                c1tx.data         <= avmm_writedata;
                if (hdr_sop) mdata_q <= mdata_q + 16'd1;
            end
        end
    end

    avmm_ccip_wr_len_fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .AW    (RSP_FIFO_AW)
    ) u_len_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (beat_acc & first_beat),
        .push_data (avmm_burstcount),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_wr    = c1rx.rspValid & (c1rx.hdr.resp_type == eRSP_WRLINE);
    assign rsp_lines = !rsp_wr         ? 9'd0 :
                       c1rx.hdr.format ? 9'(c1rx.hdr.cl_num) + 9'd1 :
                                         9'd1;
    assign fifo_pop  = ~fifo_empty & (done_lines >= 9'(fifo_head));
    assign pop_lines = fifo_pop ? 9'(fifo_head) : 9'd0;

    // Completed-line accounting and one response pulse per retired burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_lines              <= 9'd0;
            avmm_writeresponsevalid <= 1'b0;
        end else begin
            done_lines              <= done_lines + rsp_lines - pop_lines;
            avmm_writeresponsevalid <= fifo_pop;
        end
    end

    a_rsp_without_burst: assert property (
        @(posedge clk) disable iff (reset) rsp_wr |-> !fifo_empty
    );

    assign unused_bits = ^{avmm_address[5:0], c1rx.hdr.vc_used,
                           c1rx.hdr.rsvd1, c1rx.hdr.hit_miss,
                           c1rx.hdr.rsvd0, c1rx.hdr.mdata};

endmodule

// File: tb/tb_avmm_ccip_host_wr.sv
// Scoreboard bench for the Avalon-MM to CCI-P c1 write bridge.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_avmm_ccip_host_wr;
    import ccip_avmm_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           avmm_waitrequest;
    logic [47:0]    avmm_address;
    logic           avmm_write;
    logic [511:0]   avmm_writedata;
    logic [2:0]     avmm_burstcount;
    logic           avmm_writeresponsevalid;
    logic           c1TxAlmFull;
    t_if_ccip_c1_Rx c1rx;
    t_if_ccip_c1_Tx c1tx;

    avmm_ccip_host_wr #(.RSP_FIFO_DEPTH(64)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .avmm_waitrequest        (avmm_waitrequest),
        .avmm_address            (avmm_address),
        .avmm_write              (avmm_write),
        .avmm_writedata          (avmm_writedata),
        .avmm_burstcount         (avmm_burstcount),
        .avmm_writeresponsevalid (avmm_writeresponsevalid),
        .c1TxAlmFull             (c1TxAlmFull),
        .c1rx                    (c1rx),
        .c1tx                    (c1tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [41:0]  addr;
        logic         sop;
        t_ccip_clLen  len;
        logic [15:0]  mdata;
        logic [511:0] data;
    } exp_t;

    exp_t        exp_tx[$];
    int          exp_pulse = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc[$];
    int          cyc = 0;
    logic [15:0] mdata_m = 16'd0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] pat(input int tag);
        return {16{32'hA000_0000 + 32'(tag)}};
    endfunction

    function automatic void exp_beat(input logic [41:0] a, input logic sop,
                                     input t_ccip_clLen len, input int tag);
        exp_t e;
        e.addr  = a;
        e.sop   = sop;
        e.len   = len;
        e.mdata = mdata_m;
        e.data  = pat(tag);
        exp_tx.push_back(e);
        if (sop) mdata_m = mdata_m + 16'd1;
    endfunction

    // Monitor: compare every presented c1 request and response pulse.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (c1tx.valid === 1'b1) begin
            n_cmp++;
            if (exp_tx.size() == 0) begin
                n_bad++;
                $display("FAIL c1tx_unexpected actual addr=%h sop=%b required none",
                         c1tx.hdr.address, c1tx.hdr.sop);
            end else begin
                e  = exp_tx.pop_front();
                ok = (c1tx.hdr.address === e.addr) &&
                     (c1tx.hdr.sop === e.sop) &&
                     (c1tx.hdr.cl_len === e.len) &&
                     (c1tx.hdr.req_type === eREQ_WRLINE_I) &&
                     (c1tx.hdr.vc_sel === eVC_VH0) &&
                     (c1tx.data === e.data) &&
                     (!e.sop || (c1tx.hdr.mdata === e.mdata));
                if (!ok) begin
                    n_bad++;
                    $display("FAIL c1tx_beat actual addr=%h sop=%b len=%0d md=%0d d=%h required addr=%h sop=%b len=%0d md=%0d d=%h",
                             c1tx.hdr.address, c1tx.hdr.sop, c1tx.hdr.cl_len,
                             c1tx.hdr.mdata, c1tx.data[31:0], e.addr, e.sop,
                             e.len, e.mdata, e.data[31:0]);
                end
            end
        end
        if (avmm_writeresponsevalid === 1'b1) begin
            n_cmp++;
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            if (exp_pulse == 0) begin
                n_bad++;
                $display("FAIL wr_response_unexpected actual pulse required none");
            end else begin
                exp_pulse--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input logic [47:0] addr, input logic [2:0] len,
                        input int tag);
        int guard;
        guard           = 0;
        avmm_write      = 1'b1;
        avmm_address    = addr;
        avmm_burstcount = len;
        avmm_writedata  = pat(tag);
        @(negedge clk);
        while (avmm_waitrequest && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        if (avmm_waitrequest) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept_timeout actual waitrequest=1 required 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input logic fmt, input logic [1:0] cl,
                       input logic [15:0] md);
        c1rx.rspValid       = 1'b1;
        c1rx.hdr            = '0;
        c1rx.hdr.resp_type  = eRSP_WRLINE;
        c1rx.hdr.vc_used    = eVC_VH0;
        c1rx.hdr.format     = fmt;
        c1rx.hdr.cl_num     = cl;
        c1rx.hdr.mdata      = md;
        tick();
        c1rx.rspValid       = 1'b0;
    endtask

    // Wait until every expected request and pulse has been seen.
    task automatic drain(input string name);
        int g;
        g = 0;
        while ((exp_tx.size() != 0 || exp_pulse != 0) && g < 400) begin
            tick();
            g++;
        end
        n_cmp++;
        if (exp_tx.size() != 0 || exp_pulse != 0) begin
            n_bad++;
            $display("FAIL %s_drain actual tx_left=%0d pulses_left=%0d required 0/0",
                     name, exp_tx.size(), exp_pulse);
        end
        repeat (3) tick();
    endtask

    initial begin
        int p0;
        reset           = 1'b1;
        avmm_write      = 1'b0;
        avmm_address    = '0;
        avmm_burstcount = 3'd1;
        avmm_writedata  = '0;
        c1TxAlmFull     = 1'b0;
        c1rx            = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_waitrequest", 64'(avmm_waitrequest), 64'd1);
        chk("reset_c1tx_valid", 64'(c1tx.valid), 64'd0);
        chk("reset_wrrsp", 64'(avmm_writeresponsevalid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) tick();

        // Aligned 4-line burst, one packed response.
        for (int i = 0; i < 4; i++)
            exp_beat(42'h40 + 42'(i), i == 0, eCL_LEN_4, 10 + i);
        for (int i = 0; i < 4; i++) beat(48'h1000, 3'd4, 10 + i);
        avmm_write = 1'b0;
        repeat (3) tick();
        exp_pulse++;
        rsp(1'b1, 2'd3, 16'd0);
        drain("aligned4");

        // Misaligned 4-line burst is chopped; responses reversed.
        for (int i = 0; i < 4; i++)
            exp_beat(42'h41 + 42'(i), 1'b1, eCL_LEN_1, 20 + i);
        for (int i = 0; i < 4; i++) beat(48'h1040, 3'd4, 20 + i);
        avmm_write = 1'b0;
        repeat (3) tick();
        p0 = pulse_cnt;
        rsp(1'b0, 2'd0, 16'd4);
        rsp(1'b0, 2'd0, 16'd3);
        rsp(1'b0, 2'd0, 16'd2);
        repeat (5) tick();
        chk("chop4_no_early_pulse", 64'(pulse_cnt - p0), 64'd0);
        exp_pulse++;
        rsp(1'b0, 2'd0, 16'd1);
        drain("chop4");

        // Chopped 3-burst then aligned 2-burst back to back.
        for (int i = 0; i < 3; i++)
            exp_beat(42'h80 + 42'(i), 1'b1, eCL_LEN_1, 30 + i);
        exp_beat(42'h82, 1'b1, eCL_LEN_2, 33);
        exp_beat(42'h83, 1'b0, eCL_LEN_2, 34);
        for (int i = 0; i < 3; i++) beat(48'h2000, 3'd3, 30 + i);
        for (int i = 0; i < 2; i++) beat(48'h2080, 3'd2, 33 + i);
        avmm_write = 1'b0;
        repeat (3) tick();
        rsp(1'b0, 2'd0, 16'd0);
        rsp(1'b0, 2'd0, 16'd0);
        exp_pulse++;
        rsp(1'b0, 2'd0, 16'd0);
        repeat (3) tick();
        exp_pulse++;
        rsp(1'b1, 2'd1, 16'd0);
        drain("chop3_len2");

        // Almost-full raised while beat 2 is presented.
        for (int i = 0; i < 4; i++)
            exp_beat(42'hC0 + 42'(i), i == 0, eCL_LEN_4, 40 + i);
        beat(48'h3000, 3'd4, 40);
        beat(48'h3000, 3'd4, 41);
        c1TxAlmFull = 1'b1;
        beat(48'h3000, 3'd4, 42);
        avmm_write     = 1'b1;
        avmm_writedata = pat(43);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("almfull_waitrequest", 64'(avmm_waitrequest), 64'd1);
        end
        @(posedge clk);
        #1;
        c1TxAlmFull = 1'b0;
        beat(48'h3000, 3'd4, 43);
        avmm_write = 1'b0;
        repeat (3) tick();
        exp_pulse++;
        rsp(1'b1, 2'd3, 16'd0);
        drain("almfull");

        // Fill all 64 length slots; the 65th burst must stall.
        for (int i = 0; i < 64; i++) begin
            exp_beat(42'h4000 + 42'(i), 1'b1, eCL_LEN_1, 100 + i);
            beat(48'h10_0000 + (48'(i) << 6), 3'd1, 100 + i);
        end
        avmm_write      = 1'b1;
        avmm_address    = 48'h10_0000 + (48'd64 << 6);
        avmm_burstcount = 3'd1;
        avmm_writedata  = pat(164);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fifo_full_stall", 64'(avmm_waitrequest), 64'd1);
        end
        @(posedge clk);
        #1;
        exp_pulse++;
        rsp(1'b0, 2'd0, 16'd0);
        exp_beat(42'h4040, 1'b1, eCL_LEN_1, 164);
        beat(48'h10_0000 + (48'd64 << 6), 3'd1, 164);
        avmm_write = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 64; i++) begin
            exp_pulse++;
            rsp(1'b0, 2'd0, 16'd0);
        end
        drain("fifo_full");

        // Packed 4-line response retires L=1,1,2 on consecutive cycles.
        exp_beat(42'h100, 1'b1, eCL_LEN_1, 50);
        exp_beat(42'h101, 1'b1, eCL_LEN_1, 51);
        exp_beat(42'h102, 1'b1, eCL_LEN_2, 52);
        exp_beat(42'h103, 1'b0, eCL_LEN_2, 53);
        beat(48'h4000, 3'd1, 50);
        beat(48'h4040, 3'd1, 51);
        beat(48'h4080, 3'd2, 52);
        beat(48'h4080, 3'd2, 53);
        avmm_write = 1'b0;
        repeat (3) tick();
        pulse_cyc.delete();
        exp_pulse += 3;
        rsp(1'b1, 2'd3, 16'd0);
        drain("packed_multi");
        chk("packed_pulse_count", 64'(pulse_cyc.size()), 64'd3);
        if (pulse_cyc.size() == 3) begin
            chk("packed_pulse_gap0", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd1);
            chk("packed_pulse_gap1", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'd1);
        end

        // Response add coinciding with a pop keeps the count exact.
        exp_beat(42'h104, 1'b1, eCL_LEN_1, 60);
        exp_beat(42'h105, 1'b1, eCL_LEN_1, 61);
        beat(48'h4100, 3'd1, 60);
        beat(48'h4140, 3'd1, 61);
        avmm_write = 1'b0;
        repeat (3) tick();
        exp_pulse += 2;
        rsp(1'b0, 2'd0, 16'd0);
        rsp(1'b0, 2'd0, 16'd0);
        drain("same_cycle");
        exp_beat(42'h106, 1'b1, eCL_LEN_1, 62);
        beat(48'h4180, 3'd1, 62);
        avmm_write = 1'b0;
        repeat (3) tick();
        exp_pulse++;
        rsp(1'b0, 2'd0, 16'd0);
        drain("same_cycle_after");

        // Reset mid-burst with two bursts outstanding.
        exp_beat(42'h180, 1'b1, eCL_LEN_2, 70);
        exp_beat(42'h181, 1'b0, eCL_LEN_2, 71);
        exp_beat(42'h182, 1'b1, eCL_LEN_2, 72);
        exp_beat(42'h183, 1'b0, eCL_LEN_2, 73);
        exp_beat(42'h1C0, 1'b1, eCL_LEN_4, 74);
        beat(48'h6000, 3'd2, 70);
        beat(48'h6000, 3'd2, 71);
        beat(48'h6080, 3'd2, 72);
        beat(48'h6080, 3'd2, 73);
        beat(48'h7000, 3'd4, 74);
        avmm_write = 1'b0;
        reset      = 1'b1;
        mdata_m    = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_waitrequest", 64'(avmm_waitrequest), 64'd1);
        chk("midreset_c1tx_valid", 64'(c1tx.valid), 64'd0);
        chk("midreset_wrrsp", 64'(avmm_writeresponsevalid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("midreset_tx_drained", 64'(exp_tx.size()), 64'd0);
        exp_beat(42'h140, 1'b1, eCL_LEN_1, 80);
        beat(48'h5000, 3'd1, 80);
        avmm_write = 1'b0;
        repeat (3) tick();
        exp_pulse++;
        rsp(1'b0, 2'd0, 16'd0);
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
